// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit accumulator micro: ALU operation select and instruction opcodes.
package cpu_pkg;

  typedef enum logic [2:0] {
    Operation_ADD  = 3'd0,
    Operation_SUB  = 3'd1,
    Operation_NOR  = 3'd2,
    Operation_NAND = 3'd3,
    Operation_XOR  = 3'd4,
    Operation_XNOR = 3'd5
  } Operation;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LD   = 4'h1,
    OP_ST   = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_NOR  = 4'h5,
    OP_NAND = 4'h6,
    OP_XOR  = 4'h7,
    OP_XNOR = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JC   = 4'hB,
    OP_JN   = 4'hC,
    OP_CLC  = 4'hD,
    OP_SEC  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

endpackage

// File: rtl/accumulator_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator micro: owns PC, IR, ACC and flags,
// drives the external combinational ALU and the synchronous program ROM / data RAM.
module accumulator_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W   = 8,
  parameter int unsigned RAM_AW = 8
) (
  input  logic              _iClk,
  input  logic              _iReset_n,
  input  logic              _iEnable,
  output logic [PC_W-1:0]   _oRomAddr,
  input  logic [15:0]       _iRomData,
  output logic [RAM_AW-1:0] _oRamAddr,
  input  logic [7:0]        _iRamRdData,
  output logic [7:0]        _oRamWrData,
  output logic              _oRamWe,
  output logic [7:0]        _oAluA,
  output logic [7:0]        _oAluB,
  output logic              _oAluC,
  output Operation          _oAluOp,
  input  logic [7:0]        _iAluResult,
  input  logic              _iAluCarry,
  input  logic              _iAluZero,
  input  logic              _iAluNeg,
  output logic [7:0]        _oAcc,
  output logic              _oFlagCarry,
  output logic              _oFlagZero,
  output logic              _oFlagNeg,
  output logic [PC_W-1:0]   _oPc,
  output logic              _oHalted
);

  localparam int unsigned IR_W = 16;
  localparam int unsigned DW   = 8;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEMRD  = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic            c_q, c_d, z_q, z_d, n_q, n_d;

  opcode_e         ir_opc, rom_opc;
  logic [DW-1:0]   operand;
  logic            rom_needs_mem;
  logic            ram_we;
  Operation        alu_op;
  logic [DW-1:0]   alu_b;
  logic            unused_ir_bits;

  assign ir_opc         = opcode_e'(ir_q[15:12]);
  assign rom_opc        = opcode_e'(_iRomData[15:12]);
  assign operand        = ir_q[11] ? _iRamRdData : ir_q[7:0];
  assign unused_ir_bits = ^ir_q[10:8];

  // Only LD and the ALU ops fetch a RAM operand; ST ignores M.
  assign rom_needs_mem = _iRomData[11] &&
                         ((rom_opc == OP_LD) || ((rom_opc >= OP_ADD) && (rom_opc <= OP_XNOR)));

  always_ff @(posedge _iClk or negedge _iReset_n) begin
    if (!_iReset_n) begin
      state_q <= S_FETCH;
    end else if (_iEnable) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = rom_needs_mem ? S_MEMRD : S_EXEC;
      S_MEMRD:  state_d = S_EXEC;
      S_EXEC:   state_d = (ir_opc == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath next values and ALU/RAM drive, decoded from the current state.
  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    acc_d  = acc_q;
    c_d    = c_q;
    z_d    = z_q;
    n_d    = n_q;
    ram_we = 1'b0;
    alu_op = Operation_ADD;
    alu_b  = '0;
    case (state_q)
      S_DECODE: begin
        ir_d = _iRomData;
        pc_d = pc_q + PC_W'(1);
      end
      S_EXEC: begin
        case (ir_opc)
          OP_LD: begin
            acc_d = operand;
            z_d   = (operand == '0);
            n_d   = operand[7];
          end
          OP_ST:   ram_we = _iEnable;
          OP_ADD, OP_SUB, OP_NOR, OP_NAND, OP_XOR, OP_XNOR: begin
            case (ir_opc)
              OP_ADD:  alu_op = Operation_ADD;
              OP_SUB:  alu_op = Operation_SUB;
              OP_NOR:  alu_op = Operation_NOR;
              OP_NAND: alu_op = Operation_NAND;
              OP_XOR:  alu_op = Operation_XOR;
              default: alu_op = Operation_XNOR;
            endcase
            alu_b = operand;
            acc_d = _iAluResult;
            c_d   = ((ir_opc == OP_ADD) || (ir_opc == OP_SUB)) ? _iAluCarry : 1'b0;
            z_d   = _iAluZero;
            n_d   = _iAluNeg;
          end
          OP_JMP:  pc_d = PC_W'(ir_q[7:0]);
          OP_JZ:   if (z_q) pc_d = PC_W'(ir_q[7:0]);
          OP_JC:   if (c_q) pc_d = PC_W'(ir_q[7:0]);
          OP_JN:   if (n_q) pc_d = PC_W'(ir_q[7:0]);
          OP_CLC:  c_d = 1'b0;
          OP_SEC:  c_d = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge _iClk or negedge _iReset_n) begin
    if (!_iReset_n) begin
      pc_q  <= '0;
      ir_q  <= '0;
      acc_q <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else if (_iEnable) begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      acc_q <= acc_d;
      c_q   <= c_d;
      z_q   <= z_d;
      n_q   <= n_d;
    end
  end

  assign _oRomAddr   = pc_q;
  assign _oRamAddr   = ir_q[RAM_AW-1:0];
  assign _oRamWrData = acc_q;
  assign _oRamWe     = ram_we;
  assign _oAluA      = acc_q;
  assign _oAluB      = alu_b;
  assign _oAluC      = c_q;
  assign _oAluOp     = alu_op;
  assign _oAcc       = acc_q;
  assign _oFlagCarry = c_q;
  assign _oFlagZero  = z_q;
  assign _oFlagNeg   = n_q;
  assign _oPc        = pc_q;
  assign _oHalted    = (state_q == S_HALT);

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench for accumulator_sequencer with behavioural ROM, RAM and ALU models.
module tb_accumulator_sequencer;
  import cpu_pkg::*;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct packed {
    logic [7:0]  acc;
    logic        c;
    logic        z;
    logic        n;
    logic [7:0]  pc;
    logic [15:0] cycles;
  } fin_t;

  logic        clk, rst_n, en;
  logic [7:0]  rom_addr, ram_addr, ram_rd, ram_wr;
  logic [15:0] rom_data;
  logic        ram_we;
  logic [7:0]  alu_a, alu_b, alu_res;
  logic        alu_c, alu_cy, alu_z, alu_n;
  Operation    alu_op;
  logic [7:0]  acc, pc;
  logic        fc, fz, fn, halted;

  logic [15:0] rom [256];
  logic [7:0]  ram [256];
  logic [8:0]  alu_t;
  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  int          cyc;
  logic        halted_prev = 1'b0;
  wr_t         exp_wr_q[$];
  fin_t        exp_fin_q[$];

  accumulator_sequencer #(.PC_W(8), .RAM_AW(8)) dut (
    ._iClk(clk), ._iReset_n(rst_n), ._iEnable(en),
    ._oRomAddr(rom_addr), ._iRomData(rom_data),
    ._oRamAddr(ram_addr), ._iRamRdData(ram_rd), ._oRamWrData(ram_wr), ._oRamWe(ram_we),
    ._oAluA(alu_a), ._oAluB(alu_b), ._oAluC(alu_c), ._oAluOp(alu_op),
    ._iAluResult(alu_res), ._iAluCarry(alu_cy), ._iAluZero(alu_z), ._iAluNeg(alu_n),
    ._oAcc(acc), ._oFlagCarry(fc), ._oFlagZero(fz), ._oFlagNeg(fn),
    ._oPc(pc), ._oHalted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  always @(posedge clk) begin
    ram_rd <= ram[ram_addr];
    if (ram_we) ram[ram_addr] = ram_wr;
  end

  // ALU model: ADC / SBC (C = borrow), logic ops pass carry-in through to carry-out.
  always_comb begin
    alu_t   = 9'd0;
    alu_res = 8'd0;
    alu_cy  = 1'b0;
    case (alu_op)
      Operation_ADD: begin
        alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c};
        alu_res = alu_t[7:0]; alu_cy = alu_t[8];
      end
      Operation_SUB: begin
        alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_c};
        alu_res = alu_t[7:0]; alu_cy = alu_t[8];
      end
      Operation_NOR:  begin alu_res = ~(alu_a | alu_b); alu_cy = alu_c; end
      Operation_NAND: begin alu_res = ~(alu_a & alu_b); alu_cy = alu_c; end
      Operation_XOR:  begin alu_res = alu_a ^ alu_b;    alu_cy = alu_c; end
      Operation_XNOR: begin alu_res = ~(alu_a ^ alu_b); alu_cy = alu_c; end
      default: ;
    endcase
  end
  assign alu_z = (alu_res == 8'd0);
  assign alu_n = alu_res[7];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Scoreboard consumer: RAM writes and final architectural state on entry to HALT.
  always @(negedge clk) begin
    wr_t  w;
    fin_t f;
    if (rst_n && ram_we) begin
      wr_count++;
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL ram_write_unexpected: got addr=%h data=%h, required no write", ram_addr, ram_wr);
      end else begin
        w = exp_wr_q.pop_front();
        if ({ram_addr, ram_wr} !== {w.addr, w.data}) begin
          errors++;
          $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                   ram_addr, ram_wr, w.addr, w.data);
        end
      end
    end
    if (rst_n && halted && !halted_prev) begin
      checks += 2;
      if (exp_fin_q.size() == 0) begin
        errors += 2;
        $display("FAIL halt_unexpected: halted with no expectation queued");
      end else begin
        f = exp_fin_q.pop_front();
        if ({acc, fc, fz, fn, pc} !== {f.acc, f.c, f.z, f.n, f.pc}) begin
          errors++;
          $display("FAIL final_state: got acc=%h c=%b z=%b n=%b pc=%h, required acc=%h c=%b z=%b n=%b pc=%h",
                   acc, fc, fz, fn, pc, f.acc, f.c, f.z, f.n, f.pc);
        end
        if (16'(cyc) !== f.cycles) begin
          errors++;
          $display("FAIL halt_latency: got %0d cycles, required %0d", cyc, f.cycles);
        end
      end
    end
    halted_prev = halted;
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'hF000;
      ram[i] = 8'h00;
    end
  endtask

  task automatic start();
    en    = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int max_cycles);
    int n = 0;
    while (!halted && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout: got halted=0 after %0d cycles, required halted=1", n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_mem();
    en    = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if ({acc, fc, fz, fn} !== 11'd0) begin errors++; $display("FAIL reset_acc_flags: got %h, required 0", {acc, fc, fz, fn}); end
    if (pc !== 8'd0 || rom_addr !== 8'd0) begin errors++; $display("FAIL reset_pc: got pc=%h rom_addr=%h, required 0", pc, rom_addr); end
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b, required 0", halted); end
    if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", ram_we); end
    if (alu_op !== Operation_ADD) begin errors++; $display("FAIL reset_aluop: got %0d, required ADD", alu_op); end
    if (alu_b !== 8'd0) begin errors++; $display("FAIL reset_alub: got %h, required 0", alu_b); end
  endtask

  task automatic test_ld_add();
    clear_mem();
    rom[0] = 16'h1005; rom[1] = 16'h3003; rom[2] = 16'hF000;
    exp_fin_q.push_back('{8'h08, 1'b0, 1'b0, 1'b0, 8'h03, 16'd9});
    start();
    wait_halt(40);
    repeat (4) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || pc !== 8'h03) begin
      errors++;
      $display("FAIL halt_terminal: got halted=%b pc=%h, required halted=1 pc=03", halted, pc);
    end
  endtask

  task automatic test_carry();
    clear_mem();
    rom[0] = 16'hE000; rom[1] = 16'h10FF; rom[2] = 16'h3000; rom[3] = 16'hF000;
    exp_fin_q.push_back('{8'h00, 1'b1, 1'b1, 1'b0, 8'h04, 16'd12});
    start();
    wait_halt(60);
    rom[3] = 16'hD000; rom[4] = 16'h4001; rom[5] = 16'hF000;
    exp_fin_q.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 8'h06, 16'd18});
    start();
    wait_halt(80);
  endtask

  task automatic test_mem_st();
    int w0;
    clear_mem();
    ram[8'h10] = 8'h3C;
    rom[0] = 16'hE000; rom[1] = 16'h100F; rom[2] = 16'h7810; rom[3] = 16'h2020; rom[4] = 16'hF000;
    exp_wr_q.push_back('{8'h20, 8'h33});
    exp_fin_q.push_back('{8'h33, 1'b0, 1'b0, 1'b0, 8'h05, 16'd16});
    w0 = wr_count;
    start();
    wait_halt(80);
    checks += 2;
    if (ram[8'h20] !== 8'h33) begin errors++; $display("FAIL st_ram_content: got %h, required 33", ram[8'h20]); end
    if (wr_count - w0 !== 1) begin errors++; $display("FAIL st_pulse_count: got %0d, required 1", wr_count - w0); end
  endtask

  task automatic test_jumps();
    clear_mem();
    rom[0] = 16'h1000; rom[1] = 16'hA040;
    exp_fin_q.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 8'h41, 16'd9});
    start();
    wait_halt(40);
    rom[0] = 16'h1001;
    exp_fin_q.push_back('{8'h01, 1'b0, 1'b0, 1'b0, 8'h03, 16'd9});
    start();
    wait_halt(40);
    clear_mem();
    rom[0] = 16'hB010; rom[1] = 16'hE000; rom[2] = 16'h90FF; rom[8'hFF] = 16'h0000;
    exp_fin_q.push_back('{8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 16'd18});
    start();
    wait_halt(80);
    clear_mem();
    rom[0] = 16'h1080; rom[1] = 16'hC030;
    exp_fin_q.push_back('{8'h80, 1'b0, 1'b0, 1'b1, 8'h31, 16'd9});
    start();
    wait_halt(40);
  endtask

  task automatic test_enable_hold();
    clear_mem();
    ram[8'h10] = 8'hA5;
    rom[0] = 16'h1810;
    exp_fin_q.push_back('{8'hA5, 1'b0, 1'b0, 1'b1, 8'h02, 16'd12});
    start();
    repeat (2) @(posedge clk);
    #1 en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (pc !== 8'h01 || acc !== 8'h00 || ram_addr !== 8'h10 || halted !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold[%0d]: got pc=%h acc=%h ram_addr=%h halted=%b, required pc=01 acc=00 ram_addr=10 halted=0",
                 i, pc, acc, ram_addr, halted);
      end
      @(posedge clk);
    end
    #1 en = 1'b1;
    wait_halt(40);
    clear_mem();
    rom[0] = 16'h1011; rom[1] = 16'h2070;
    exp_wr_q.push_back('{8'h70, 8'h11});
    exp_fin_q.push_back('{8'h11, 1'b0, 1'b0, 1'b0, 8'h03, 16'd10});
    start();
    repeat (5) @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b0) begin errors++; $display("FAIL enable_gates_we: got %b, required 0", ram_we); end
    @(posedge clk);
    #1 en = 1'b1;
    wait_halt(40);
  endtask

  task automatic test_reset_during_st();
    int w0;
    clear_mem();
    rom[0] = 16'h105A; rom[1] = 16'h2060;
    start();
    repeat (5) @(posedge clk);
    w0 = wr_count;
    #1 rst_n = 1'b0;
    #1;
    checks += 2;
    if (ram_we !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_we: got we=%b halted=%b, required 0 0", ram_we, halted);
    end
    if ({acc, pc, rom_addr, fc, fz, fn} !== 27'd0) begin
      errors++;
      $display("FAIL reset_async_state: got acc=%h pc=%h rom_addr=%h, required 0", acc, pc, rom_addr);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ram[8'h60] !== 8'h00 || wr_count !== w0) begin
      errors++;
      $display("FAIL reset_aborts_st: got ram=%h writes=%0d, required ram=00 writes=0", ram[8'h60], wr_count - w0);
    end
    exp_wr_q.push_back('{8'h60, 8'h5A});
    exp_fin_q.push_back('{8'h5A, 1'b0, 1'b0, 1'b0, 8'h03, 16'd9});
    rst_n = 1'b1;
    checks++;
    if (rom_addr !== 8'h00) begin errors++; $display("FAIL restart_fetch: got rom_addr=%h, required 00", rom_addr); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pc !== 8'h01) begin errors++; $display("FAIL restart_pc: got %h, required 01", pc); end
    wait_halt(40);
  endtask

  initial begin
    en    = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_ld_add();
    test_carry();
    test_mem_st();
    test_jumps();
    test_enable_hold();
    test_reset_during_st();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_wr_q.size() != 0 || exp_fin_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d writes and %0d halts outstanding, required 0",
               exp_wr_q.size(), exp_fin_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
